// File: rtl/pc_stack_ctrl_if.sv
// Core/LIFO-facing bus of the PC sequencer. The irq signal exists only when PC_IRQ_EN is defined.
interface pc_stack_ctrl_if;
`ifdef PC_IRQ_EN
    logic        irq;
`endif
    logic        stall;
    logic        jmp;
    logic        call;
    logic        ret;
    logic [10:0] target;
    logic [10:0] stack_dout;
    logic [10:0] pc;
    logic        stack_wr_en;
    logic        stack_rd_en;
    logic [10:0] stack_din;
    logic        busy;
    logic [4:0]  depth;
    logic        overflow;
    logic        underflow;

    modport slave (
`ifdef PC_IRQ_EN
        input  irq,
`endif
        input  stall, jmp, call, ret, target, stack_dout,
        output pc, stack_wr_en, stack_rd_en, stack_din, busy, depth, overflow, underflow
    );

    modport master (
`ifdef PC_IRQ_EN
        output irq,
`endif
        output stall, jmp, call, ret, target, stack_dout,
        input  pc, stack_wr_en, stack_rd_en, stack_din, busy, depth, overflow, underflow
    );
endinterface

// File: rtl/pc_stack_ctrl.sv
// Program-counter sequencer with return-address stack control and shadow depth tracking.
// Optional interrupt entry (vector jump plus IRQ mask) is enabled by defining PC_IRQ_EN.
module pc_stack_ctrl #(
    parameter logic [10:0] RESET_PC   = 11'h000
`ifdef PC_IRQ_EN
   ,parameter logic [10:0] IRQ_VECTOR = 11'h7F0
`endif
) (
    input  logic           clk,
    input  logic           rst,
    pc_stack_ctrl_if.slave bus
);

    typedef enum logic {RUN, RET_WAIT} state_e;

    state_e      state_q, state_d;
    logic [10:0] pc_q, pc_d;
    logic [4:0]  depth_q, depth_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
`ifdef PC_IRQ_EN
    logic        irqMask_q, irqMask_d;
`endif
    logic [10:0] pcInc;
    logic        wrEn, rdEn, pushPc, push, pop;

    assign pcInc = pc_q + 11'd1;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        depth_d     = depth_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
`ifdef PC_IRQ_EN
        irqMask_d   = irqMask_q;
`endif
        wrEn   = 1'b0;
        rdEn   = 1'b0;
        pushPc = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;

        if (!bus.stall) begin
            unique case (state_q)
                RUN: begin
                    if (bus.call) begin
                        push = 1'b1;
                        pc_d = bus.target;
`ifdef PC_IRQ_EN
                    end else if (bus.irq && !irqMask_q) begin
                        // Push the current pc so the interrupted instruction re-executes.
                        push      = 1'b1;
                        pushPc    = 1'b1;
                        pc_d      = IRQ_VECTOR;
                        irqMask_d = 1'b1;
`endif
                    end else if (bus.ret) begin
                        pop     = 1'b1;
                        state_d = RET_WAIT;
                    end else if (bus.jmp) begin
                        pc_d = bus.target;
                    end else begin
                        pc_d = pcInc;
                    end
                end
                RET_WAIT: begin
                    pc_d    = bus.stack_dout;
                    state_d = RUN;
`ifdef PC_IRQ_EN
                    irqMask_d = 1'b0;
`endif
                end
                default: state_d = RUN;
            endcase
        end

        // Saturating depth; the LIFO itself overwrites its top entry on overflow.
        if (push) begin
            wrEn = 1'b1;
            if (depth_q < 5'd15) depth_d = depth_q + 5'd1;
            else                 overflow_d = 1'b1;
        end
        if (pop) begin
            rdEn = 1'b1;
            if (depth_q != 5'd0) depth_d = depth_q - 5'd1;
            else                 underflow_d = 1'b1;
        end

        if (rst) begin
            wrEn   = 1'b0;
            rdEn   = 1'b0;
            pushPc = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            depth_q     <= 5'd0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`ifdef PC_IRQ_EN
            irqMask_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
`ifdef PC_IRQ_EN
            irqMask_q   <= irqMask_d;
`endif
        end
    end

    assign bus.pc          = pc_q;
    assign bus.stack_wr_en = wrEn;
    assign bus.stack_rd_en = rdEn;
    assign bus.stack_din   = pushPc ? pc_q : pcInc;
    assign bus.busy        = (state_q == RET_WAIT);
    assign bus.depth       = depth_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// Testbench for pc_stack_ctrl: directed scenarios then random traffic, checked against a
// queue-based reference model; a small LIFO model feeds stack_dout back to the DUT.
module tb_pc_stack_ctrl;

    localparam logic [10:0] RESET_PC  = 11'h000;
    localparam logic [10:0] IRQ_VEC   = 11'h7F0;
    localparam logic [10:0] UNDER_VAL = 11'h3A5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_stack_ctrl_if bus();

    pc_stack_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Upstream LIFO: stores pushed addresses, presents the popped one on stack_dout.
    logic [10:0] lifoMem [0:14];
    int          lifoSp = 0;
    always @(posedge clk) begin
        if (rst) begin
            lifoSp         <= 0;
            bus.stack_dout <= 11'h000;
        end else if (bus.stack_wr_en) begin
            if (lifoSp < 15) begin
                lifoMem[lifoSp] <= bus.stack_din;
                lifoSp          <= lifoSp + 1;
            end else begin
                lifoMem[14] <= bus.stack_din;
            end
        end else if (bus.stack_rd_en) begin
            if (lifoSp > 0) begin
                bus.stack_dout <= lifoMem[lifoSp-1];
                lifoSp         <= lifoSp - 1;
            end else begin
                bus.stack_dout <= UNDER_VAL;
            end
        end
    end

    // Reference model state: return addresses kept as a queue, depth is its size.
    logic [10:0] mPc = RESET_PC;
    logic [10:0] mStack [$];
    logic [10:0] mPending = 11'h000;
    bit          mWait = 1'b0;
    bit          mOvf  = 1'b0;
    bit          mUnf  = 1'b0;
    bit          mMask = 1'b0;

    task automatic checkOutput(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelPush(input logic [10:0] v);
        if (mStack.size() < 15) mStack.push_back(v);
        else begin
            mStack[14] = v;
            mOvf = 1'b1;
        end
    endtask

    task automatic modelEdge(input bit r, s, j, c, rt, input logic [10:0] tgt, input bit irqTake);
        if (r) begin
            mPc = RESET_PC;
            mStack.delete();
            mWait = 1'b0; mOvf = 1'b0; mUnf = 1'b0; mMask = 1'b0;
        end else if (s) begin
            mPc = mPc;
        end else if (mWait) begin
            mPc = mPending; mWait = 1'b0; mMask = 1'b0;
        end else if (c) begin
            modelPush(mPc + 11'd1);
            mPc = tgt;
        end else if (irqTake) begin
            modelPush(mPc);
            mPc = IRQ_VEC; mMask = 1'b1;
        end else if (rt) begin
            if (mStack.size() > 0) mPending = mStack.pop_back();
            else begin
                mPending = UNDER_VAL;
                mUnf = 1'b1;
            end
            mWait = 1'b1;
        end else if (j) begin
            mPc = tgt;
        end else begin
            mPc = mPc + 11'd1;
        end
    endtask

    task automatic applyStimulus(input bit r, s, j, c, rt, input logic [10:0] tgt, input bit iq);
        bit          irqTake, active, expWr, expRd;
        logic [10:0] expDin;
        @(negedge clk);
        rst        = r;
        bus.stall  = s;
        bus.jmp    = j;
        bus.call   = c;
        bus.ret    = rt;
        bus.target = tgt;
`ifdef PC_IRQ_EN
        bus.irq = iq;
        irqTake = iq && !mMask && !c;
`else
        irqTake = 1'b0 & iq;
`endif
        active = !r && !s && !mWait;
        expWr  = active && (c || irqTake);
        expRd  = active && !c && !irqTake && rt;
        expDin = (active && !c && irqTake) ? mPc : mPc + 11'd1;
        #1;
        checkOutput("stack_wr_en", 11'(bus.stack_wr_en), 11'(expWr));
        checkOutput("stack_rd_en", 11'(bus.stack_rd_en), 11'(expRd));
        checkOutput("stack_din", bus.stack_din, expDin);
        checkOutput("busy", 11'(bus.busy), 11'(mWait));
        @(posedge clk);
        modelEdge(r, s, j, c, rt, tgt, irqTake);
        #1;
        checkOutput("pc", bus.pc, mPc);
        checkOutput("depth", 11'(bus.depth), 11'(mStack.size()));
        checkOutput("overflow", 11'(bus.overflow), 11'(mOvf));
        checkOutput("underflow", 11'(bus.underflow), 11'(mUnf));
    endtask

    initial begin
        bus.stall = 1'b0; bus.jmp = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.target = 11'h000;
`ifdef PC_IRQ_EN
        bus.irq = 1'b0;
`endif
        $display("[TB] reset and idle stepping");
        applyStimulus(1, 0, 0, 0, 0, 11'h000, 0);
        applyStimulus(1, 0, 0, 0, 0, 11'h000, 0);
        checkOutput("reset_pc", bus.pc, RESET_PC);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 0, 0, 11'h000, 0);
        checkOutput("pc_at_010", bus.pc, 11'h010);

        $display("[TB] call then ret");
        applyStimulus(0, 0, 0, 1, 0, 11'h200, 0);
        applyStimulus(0, 0, 0, 0, 1, 11'h000, 0);
        applyStimulus(0, 0, 0, 0, 0, 11'h000, 0);
        checkOutput("ret_pc_011", bus.pc, 11'h011);
        applyStimulus(0, 0, 0, 0, 0, 11'h000, 0);

        $display("[TB] overflow on 16 calls");
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 1, 0, 11'($urandom), 0);
        checkOutput("ovf_depth", 11'(bus.depth), 11'd15);
        applyStimulus(0, 0, 0, 0, 1, 11'h000, 0);
        applyStimulus(0, 0, 0, 0, 0, 11'h000, 0);
        checkOutput("ovf_pop_depth", 11'(bus.depth), 11'd14);

        $display("[TB] underflow");
        applyStimulus(1, 0, 0, 0, 0, 11'h000, 0);
        applyStimulus(0, 0, 0, 0, 1, 11'h000, 0);
        applyStimulus(0, 0, 0, 0, 0, 11'h000, 0);
        applyStimulus(0, 0, 0, 0, 0, 11'h000, 0);

        $display("[TB] pc wrap on call");
        applyStimulus(0, 0, 1, 0, 0, 11'h7FF, 0);
        applyStimulus(0, 0, 0, 1, 0, 11'h100, 0);
        applyStimulus(0, 0, 0, 0, 0, 11'h000, 0);
        applyStimulus(0, 0, 0, 0, 1, 11'h000, 0);
        applyStimulus(0, 0, 0, 0, 0, 11'h000, 0);
        checkOutput("wrap_ret_pc", bus.pc, 11'h000);

        $display("[TB] stalled RET_WAIT then reset");
        applyStimulus(0, 0, 0, 1, 0, 11'h345, 0);
        applyStimulus(0, 0, 0, 0, 1, 11'h000, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 11'h000, 0);
        applyStimulus(1, 0, 0, 0, 0, 11'h000, 0);
        applyStimulus(0, 0, 0, 0, 0, 11'h000, 0);

`ifdef PC_IRQ_EN
        $display("[TB] interrupt entry and mask");
        applyStimulus(0, 0, 1, 0, 0, 11'h020, 0);
        applyStimulus(0, 0, 0, 0, 0, 11'h000, 1);
        applyStimulus(0, 0, 0, 0, 0, 11'h000, 1);
        applyStimulus(0, 0, 0, 0, 1, 11'h000, 0);
        applyStimulus(0, 0, 0, 0, 0, 11'h000, 0);
        checkOutput("irq_ret_pc", bus.pc, 11'h020);
        applyStimulus(0, 0, 0, 0, 0, 11'h000, 1);
        applyStimulus(0, 0, 0, 0, 1, 11'h000, 0);
        applyStimulus(0, 0, 0, 0, 0, 11'h000, 0);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(63) == 0, $urandom_range(7) == 0,
                          $urandom_range(3) == 0, $urandom_range(5) == 0,
                          $urandom_range(4) == 0, 11'($urandom), $urandom_range(9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
